lutram_bist_ctrl: RTL

On-chip march-test sequencer for the LUTRAM under test. It drives the LUTRAM write-enable, address and data-in directly, reads back the data-out, and compares it against the expected pattern. It sits between the LUTRAM instance and a status/JTAG readout, and owns the LUTRAM port while a test runs. It reports a saturating mismatch count and the first failing address, so a full-array check runs at fabric speed instead of one JTAG instruction per access.

---
 rtl/lutram_bist_pkg.sv | 31 +++
 rtl/lutram_bist_addr_gen.sv | 45 ++++
 rtl/lutram_bist_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/lutram_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lutram_bist_pkg
// Description : Shared types for the LUTRAM march-test sequencer: the FSM
//               state encoding and the expected-data polarity of each read.
// Revision    : 1.0 - initial release
// ============================================================================
package lutram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_M0_W = 3'd1,
        ST_M1_R = 3'd2,
        ST_M1_W = 3'd3,
        ST_M2_R = 3'd4,
        ST_M2_W = 3'd5,
        ST_M3_R = 3'd6,
        ST_DONE = 3'd7
    } bist_state_e;

    // Expected polarity of read data relative to the background pattern P
    localparam logic POL_P     = 1'b0;
    localparam logic POL_NOT_P = 1'b1;

    // Only the M2 read element expects the inverted background
    function automatic logic read_polarity(input bist_state_e st);
        return (st == ST_M2_R) ? POL_NOT_P : POL_P;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lutram_bist_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : lutram_bist_addr_gen
// Description : Up/down address counter for the march sequencer with
//               load-zero / load-last controls and first/last flags.
// Revision    : 1.0 - initial release
// ============================================================================
module lutram_bist_addr_gen #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_zero,
    input  logic                  load_last,
    input  logic                  inc,
    input  logic                  dec,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  is_first,
    output logic                  is_last
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

    // Address register; loads take priority over counting
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr <= '0;
        end else if (load_zero) begin
            addr <= '0;
        end else if (load_last) begin
            addr <= LAST_ADDR;
        end else if (inc) begin
            addr <= addr + ONE;
        end else if (dec) begin
            addr <= addr - ONE;
        end
    end

    assign is_first = (addr == '0);
    assign is_last  = (addr == LAST_ADDR);

endmodule
`default_nettype wire

// File: rtl/lutram_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lutram_bist_ctrl
// Description : March-test sequencer for a LUTRAM with asynchronous read.
//               Runs M0..M3 (write P / r P w ~P / r ~P w P / r P), counts
//               mismatches (saturating) and captures the first failing address.
// Revision    : 1.0 - initial release
// ============================================================================
module lutram_bist_ctrl
    import lutram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 256,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [DATA_WIDTH-1:0]    pattern_i,
    output logic                     lutram_we_o,
    output logic [ADDR_WIDTH-1:0]    lutram_addr_o,
    output logic [DATA_WIDTH-1:0]    lutram_di_o,
    input  logic [DATA_WIDTH-1:0]    lutram_do_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     fail_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
    output logic [ADDR_WIDTH-1:0]    first_fail_addr_o
);

    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = {ERR_CNT_WIDTH{1'b1}};
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = ERR_CNT_WIDTH'(1);

    bist_state_e           state;
    bist_state_e           state_next;
    logic [DATA_WIDTH-1:0] pattern;
    logic [DATA_WIDTH-1:0] expected;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  is_first;
    logic                  is_last;
    logic                  load_zero;
    logic                  load_last;
    logic                  inc;
    logic                  dec;
    logic                  start_accept;
    logic                  is_read;
    logic                  mismatch;

    lutram_bist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_addr_gen (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_zero (load_zero),
        .load_last (load_last),
        .inc       (inc),
        .dec       (dec),
        .addr      (addr),
        .is_first  (is_first),
        .is_last   (is_last)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and address-counter control
    always_comb begin
        state_next = state;
        load_zero  = 1'b0;
        load_last  = 1'b0;
        inc        = 1'b0;
        dec        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_M0_W;
                    load_zero  = 1'b1;
                end
            end
            ST_M0_W: begin
                if (is_last) begin
                    state_next = ST_M1_R;
                    load_zero  = 1'b1;
                end else begin
                    inc = 1'b1;
                end
            end
            ST_M1_R: state_next = ST_M1_W;
            ST_M1_W: begin
                if (is_last) begin
                    state_next = ST_M2_R;
                    load_last  = 1'b1;
                end else begin
                    state_next = ST_M1_R;
                    inc        = 1'b1;
                end
            end
            ST_M2_R: state_next = ST_M2_W;
            ST_M2_W: begin
                if (is_first) begin
                    state_next = ST_M3_R;
                    load_last  = 1'b1;
                end else begin
                    state_next = ST_M2_R;
                    dec        = 1'b1;
                end
            end
            ST_M3_R: begin
                if (is_first) begin
                    state_next = ST_DONE;
                end else begin
                    dec = 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Port decode and read-compare, purely from state, address and pattern
    always_comb begin
        start_accept  = (state == ST_IDLE) && start_i;
        lutram_we_o   = (state == ST_M0_W) || (state == ST_M1_W) || (state == ST_M2_W);
        lutram_di_o   = (state == ST_M1_W) ? ~pattern : pattern;
        lutram_addr_o = addr;
        busy_o        = (state != ST_IDLE) && (state != ST_DONE);
        done_o        = (state == ST_DONE);
        is_read       = (state == ST_M1_R) || (state == ST_M2_R) || (state == ST_M3_R);
        expected      = (read_polarity(state) == POL_NOT_P) ? ~pattern : pattern;
        mismatch      = is_read && (lutram_do_i != expected);
    end

    // Background pattern, latched when a run is accepted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pattern <= '0;
        end else if (start_accept) begin
            pattern <= pattern_i;
        end
    end

    // Result registers: cleared on start, updated on each mismatch, held otherwise
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_o         <= '0;
            fail_o            <= 1'b0;
            first_fail_addr_o <= '0;
        end else if (start_accept) begin
            err_cnt_o         <= '0;
            fail_o            <= 1'b0;
            first_fail_addr_o <= '0;
        end else if (mismatch) begin
            if (err_cnt_o != ERR_MAX) begin
                err_cnt_o <= err_cnt_o + ERR_ONE;
            end
            fail_o <= 1'b1;
            if (!fail_o) begin
                first_fail_addr_o <= addr;
            end
        end
    end

endmodule
`default_nettype wire
